// File: rtl/spi_adc_slave.sv
// SPI responder for the ADC end of the configuration link: address-matched config write plus sample readback.
// Optional even-parity bit on the frame is enabled with `define SPI_SLV_PARITY_EN.
module spi_adc_slave #(
    parameter logic [14:0] ADDR     = 15'h0190,
    parameter int unsigned SAMPLE_W = 12
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic                SS,
    input  logic                MOSI,
    input  logic [SAMPLE_W-1:0] adc_sample,
    output logic                MISO,
    output logic [3:0]          cfg_data,
    output logic                cfg_update,
    output logic                frame_err,
    output logic                busy
);

`ifdef SPI_SLV_PARITY_EN
    localparam int unsigned FW = 20;
`else
    localparam int unsigned FW = 19;
`endif
    localparam logic [4:0] LAST    = 5'(FW - 1);
    localparam logic [4:0] TX_LAST = 5'(SAMPLE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_TX, S_WAIT} state_e;

    state_e              state_q, state_d;
    logic [FW-2:0]       sr_q, sr_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4:0]          txl_q, txl_d;
    logic [SAMPLE_W-1:0] tx_sr_q, tx_sr_d;
    logic                miso_q, miso_d;
    logic [3:0]          cfg_q, cfg_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;

    logic [FW-1:0]       frame;
    logic                last_bit;
    logic                addr_ok;
    logic                par_ok;
    logic                accept;

    // The final bit is taken straight from MOSI so the frame is judged on the edge that samples it.
    assign frame    = {MOSI, sr_q};
    assign last_bit = (cnt_q == LAST);
    assign addr_ok  = (frame[18:4] == ADDR);
`ifdef SPI_SLV_PARITY_EN
    assign par_ok   = ~^frame;
`else
    assign par_ok   = 1'b1;
`endif
    assign accept   = addr_ok && par_ok;

    always_ff @(posedge user_clk or negedge user_rst) begin
        if (!user_rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            txl_q   <= '0;
            tx_sr_q <= '0;
            miso_q  <= 1'b0;
            cfg_q   <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            txl_q   <= txl_d;
            tx_sr_q <= tx_sr_d;
            miso_q  <= miso_d;
            cfg_q   <= cfg_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!SS) state_d = S_RX;
            S_RX: begin
                if (SS)            state_d = S_IDLE;
                else if (last_bit) state_d = accept ? S_TX : S_WAIT;
            end
            S_TX: begin
                if (SS)                state_d = S_IDLE;
                else if (txl_q == '0)  state_d = S_WAIT;
            end
            S_WAIT: if (SS) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        txl_d   = txl_q;
        tx_sr_d = tx_sr_q;
        miso_d  = 1'b0;
        cfg_d   = cfg_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!SS) begin
                    sr_d  = {MOSI, sr_q[FW-2:1]};
                    cnt_d = 5'd1;
                end
            end
            S_RX: begin
                if (SS) begin
                    err_d = 1'b1;
                end else if (!last_bit) begin
                    sr_d  = {MOSI, sr_q[FW-2:1]};
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    err_d = !par_ok;
                    if (accept) begin
                        cfg_d   = frame[3:0];
                        upd_d   = 1'b1;
                        miso_d  = adc_sample[SAMPLE_W-1];
                        tx_sr_d = adc_sample << 1;
                        txl_d   = TX_LAST;
                    end
                end
            end
            S_TX: begin
                if (!SS && txl_q != '0) begin
                    miso_d  = tx_sr_q[SAMPLE_W-1];
                    tx_sr_d = tx_sr_q << 1;
                    txl_d   = txl_q - 5'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        MISO       = miso_q;
        cfg_data   = cfg_q;
        cfg_update = upd_q;
        frame_err  = err_q;
        busy       = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Randomised bench for spi_adc_slave; expected per-cycle outputs come from the frame rules, not the FSM.
module tb_spi_adc_slave;

    localparam logic [14:0] ADDR = 15'h0190;
    localparam int          W    = 12;
`ifdef SPI_SLV_PARITY_EN
    localparam int          FW   = 20;
`else
    localparam int          FW   = 19;
`endif

    logic         user_clk = 1'b0;
    logic         user_rst = 1'b0;
    logic         SS       = 1'b0;
    logic         MOSI     = 1'b0;
    logic [W-1:0] adc_sample = '0;
    logic         MISO;
    logic [3:0]   cfg_data;
    logic         cfg_update;
    logic         frame_err;
    logic         busy;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] cfg_m  = '0;

    always #5 user_clk = ~user_clk;

    spi_adc_slave #(
        .ADDR     (ADDR),
        .SAMPLE_W (W)
    ) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .SS         (SS),
        .MOSI       (MOSI),
        .adc_sample (adc_sample),
        .MISO       (MISO),
        .cfg_data   (cfg_data),
        .cfg_update (cfg_update),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [14:0] a, input logic [3:0] d, input bit flip);
        logic [FW-1:0] f;
        f       = '0;
        f[3:0]  = d;
        f[18:4] = a;
`ifdef SPI_SLV_PARITY_EN
        f[19]   = (^f[18:0]) ^ flip;
`endif
        return f;
    endfunction

    // SS low for n_low edges (frame bits first, random filler after), then high for two edges.
    task automatic run_frame(input string ctx, input logic [14:0] a, input logic [3:0] d,
                             input logic [W-1:0] s, input int n_low, input bit flip);
        logic [FW-1:0] f;
        bit            bad_par, acc;
        logic          e_miso, e_upd, e_err, e_busy;
        int            i;
        f          = mk_frame(a, d, flip);
        bad_par    = flip && (FW > 19);
        acc        = (n_low >= FW) && (a == ADDR) && !bad_par;
        adc_sample = s;
        for (int j = 0; j < n_low + 2; j++) begin
            SS   = (j >= n_low);
            MOSI = (j < FW) ? f[j] : 1'($urandom);
            @(posedge user_clk);
            @(negedge user_clk);
            if (j == FW - 1) adc_sample = W'($urandom);
            if (acc && j == FW - 1) cfg_m = d;
            i      = j - (FW - 1);
            e_miso = 1'b0;
            if (acc && i >= 0 && i < W && j < n_low) e_miso = s[W-1-i];
            e_upd  = acc && (j == FW - 1);
            e_err  = ((n_low < FW) && (j == n_low)) || (bad_par && n_low >= FW && j == FW - 1);
            e_busy = (j < n_low);
            check($sformatf("%s miso j=%0d", ctx, j), 32'(MISO), 32'(e_miso));
            check($sformatf("%s upd j=%0d", ctx, j), 32'(cfg_update), 32'(e_upd));
            check($sformatf("%s err j=%0d", ctx, j), 32'(frame_err), 32'(e_err));
            check($sformatf("%s busy j=%0d", ctx, j), 32'(busy), 32'(e_busy));
            check($sformatf("%s cfg j=%0d", ctx, j), 32'(cfg_data), 32'(cfg_m));
        end
    endtask

    initial begin
        logic [FW-1:0] f;
        int            n_low;
        logic [14:0]   a;

        // Reset held with SS low and MOSI toggling.
        for (int k = 0; k < 6; k++) begin
            @(negedge user_clk);
            MOSI = ~MOSI;
            check("rst miso", 32'(MISO), 32'd0);
            check("rst cfg", 32'(cfg_data), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
            check("rst upd", 32'(cfg_update), 32'd0);
            check("rst err", 32'(frame_err), 32'd0);
        end
        SS       = 1'b1;
        user_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            MOSI = ~MOSI;
            @(negedge user_clk);
            check("post-rst busy", 32'(busy), 32'd0);
            check("post-rst miso", 32'(MISO), 32'd0);
        end

        run_frame("match", 15'h0190, 4'hA, 12'hC35, FW + W, 1'b0);
        run_frame("nomatch", 15'h0191, 4'h5, 12'hABC, FW + W, 1'b0);
        run_frame("abort10", 15'h0190, 4'h2, 12'h123, 11, 1'b0);
        run_frame("after-abort", 15'h0190, 4'h6, 12'h5A5, FW + W, 1'b0);
        run_frame("tx-abort", 15'h0190, 4'h7, 12'hFFF, FW + 3, 1'b0);
        run_frame("par-ok", 15'h0190, 4'h3, 12'h3C3, FW + W, 1'b0);
        run_frame("par-bad", 15'h0190, 4'h3, 12'h3C3, FW + W, 1'b1);

        // Asynchronous reset in the middle of TX.
        adc_sample = '1;
        f = mk_frame(ADDR, 4'h9, 1'b0);
        for (int j = 0; j <= FW; j++) begin
            SS   = 1'b0;
            MOSI = (j < FW) ? f[j] : 1'b0;
            @(posedge user_clk);
            @(negedge user_clk);
        end
        check("rstmid miso-pre", 32'(MISO), 32'd1);
        check("rstmid cfg-pre", 32'(cfg_data), 32'h9);
        #2 user_rst = 1'b0;
        #1;
        check("rstmid miso", 32'(MISO), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid cfg", 32'(cfg_data), 32'd0);
        cfg_m = '0;
        SS    = 1'b1;
        @(negedge user_clk);
        user_rst = 1'b1;
        @(negedge user_clk);
        check("rstmid busy-after", 32'(busy), 32'd0);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 3))
                0:       n_low = $urandom_range(1, FW - 1);
                1:       n_low = $urandom_range(FW, FW + W);
                2:       n_low = $urandom_range(FW + W, FW + W + 5);
                default: n_low = FW + W;
            endcase
            a = ($urandom_range(0, 1) == 0) ? ADDR : 15'($urandom);
            run_frame($sformatf("rnd%0d", r), a, 4'($urandom), W'($urandom), n_low,
                      ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_adc_slave.md
# spi_adc_slave

Single-clock SPI responder that models the ADC end of the serial configuration link. It receives 19-bit frames on MOSI while SS is low, and checks the 15-bit address field against its own address. On a match it updates a 4-bit configuration register and returns the current ADC sample on MISO, MSB first. It is the far end of the SPI master link and is used both as the ADC-side peripheral in integration and as the bench responder for the master.

## Interface
Parameters:
- ADDR, 15'h0190, device address matched against frame bits [18:4]
- SAMPLE_W, 12, width of the ADC sample returned on MISO (1..16)

Ports:
- user_clk  input  1  system clock; all logic on rising edge
- user_rst  input  1  asynchronous active-low reset
- SS  input  1  frame select, active low
- MOSI  input  1  serial data from master, LSB first
- adc_sample  input  SAMPLE_W  parallel sample, captured at frame accept
- MISO  output  1  serial response, MSB first; 0 when not transmitting
- cfg_data  output  4  last accepted configuration nibble
- cfg_update  output  1  one-cycle pulse when cfg_data is written
- frame_err  output  1  one-cycle pulse on aborted or corrupt frame
- busy  output  1  high in any state except IDLE

## Operation
Frame format: 19 bits, LSB first. Bits [3:0] are data and bits [18:4] are the address. Bit k is sampled at the k-th rising edge with SS low, counting from 0.

States:
- IDLE: waits for SS low. The edge that sees SS low samples bit 0 and moves to RX.
- RX: shifts MOSI into an internal 19-bit register with a 5-bit counter.
  - At bit 18 with address == ADDR: load cfg_data, pulse cfg_update, load the shift-out register with adc_sample, go to TX.
  - At bit 18 with address != ADDR: no update and no error; go to WAIT.
- TX: drives MISO for SAMPLE_W bits, MSB first, then goes to WAIT. MOSI is ignored.
- WAIT: MISO = 0. Stays until SS is high, then goes to IDLE. Bits after the frame are ignored.

Boundary conditions:
- SS high in RX before bit 18: pulse frame_err, no update, go to IDLE.
- SS high in TX: stop transmission, MISO = 0, go to IDLE, no frame_err. The accepted cfg_data is kept.
- SS low again in the same cycle it leaves WAIT for IDLE: not possible. SS must be high for at least one cycle between frames.
- Reset asserted at any time: all state and outputs return to reset values immediately.

Reset values: MISO = 0, cfg_data = 4'h0, cfg_update = 0, frame_err = 0, busy = 0, state = IDLE.

## Timing
- cfg_update and the new cfg_data are visible in the cycle after the edge that samples bit 18.
- MISO is registered:
  - adc_sample[SAMPLE_W-1] appears in the cycle after bit 18 is sampled.
  - Each later edge presents the next lower bit.
  - After bit 0 has been held for one cycle, MISO = 0.
- Total SS-low time for a full transaction is 19 + SAMPLE_W cycles.
- frame_err is asserted in the cycle after the edge where SS is seen high during RX.
- busy rises in the cycle after the first SS-low edge. It falls in the cycle after SS is seen high in WAIT, or on abort.

## Configuration
- Macro SPI_SLV_PARITY_EN.
  - Defined: the frame is 20 bits, and bit 19 is even parity over bits [18:0]. Address compare and accept happen at bit 19. A parity mismatch pulses frame_err, causes no update and no TX, and the block goes to WAIT. Abort rules apply up to bit 19.
  - Undefined: the frame is 19 bits and there is no parity check.

## Test plan
- Reset with SS low and MOSI toggling: MISO = 0, cfg_data = 0, busy = 0 throughout. After release, no activity until a fresh SS-low.
- Matching frame, data 4'hA, address 15'h0190, adc_sample = 12'hC35:
  - cfg_update pulses once and cfg_data = 4'hA.
  - MISO shows 1100_0011_0101 on the 12 cycles after bit 18, then 0.
- Non-matching address 15'h0191 with data 4'h5: no cfg_update, no frame_err, MISO stays 0, cfg_data keeps its previous value.
- SS raised after bit 10: frame_err pulses for one cycle, cfg_data is unchanged, busy falls. The next full frame is accepted normally.
- SS raised after 4 TX bits of sample 12'hFFF: MISO shows 1111, then 0. No frame_err, cfg_data holds the value from that frame.
- With SPI_SLV_PARITY_EN defined, frame 0x0190/4'h3:
  - Correct parity: accepted.
  - Flipped parity bit: frame_err pulse, no cfg_update, MISO = 0.
